// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: access-size encodings and the
// default queue depth.
package store_buffer_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int SB_DEPTH = 4;

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and memory-side signals of the store buffer. The slave modport is
// the buffer itself; the master modport is the core plus the data memory.
interface store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic                     core_wr_en;
    logic                     core_rd_en;
    logic [AW-1:0]            core_addr;
    logic [DW-1:0]            core_wdata;
    logic [1:0]               core_size;
    logic                     core_sign_ext;
    logic                     core_fence;
    logic [DW-1:0]            core_rdata;
    logic                     core_stall;

    logic                     mem_wr_en;
    logic                     mem_rd_en;
    logic [AW-1:0]            mem_addr;
    logic [DW-1:0]            mem_wdata;
    logic [1:0]               mem_size;
    logic                     mem_sign_ext;
    logic [DW-1:0]            mem_rdata;

    logic [$clog2(DEPTH):0]   sb_count;

    modport slave (
        input  core_wr_en, core_rd_en, core_addr, core_wdata, core_size,
               core_sign_ext, core_fence, mem_rdata,
        output core_rdata, core_stall, mem_wr_en, mem_rd_en, mem_addr,
               mem_wdata, mem_size, mem_sign_ext, sb_count
    );

    modport master (
        output core_wr_en, core_rd_en, core_addr, core_wdata, core_size,
               core_sign_ext, core_fence, mem_rdata,
        input  core_rdata, core_stall, mem_wr_en, mem_rd_en, mem_addr,
               mem_wdata, mem_size, mem_sign_ext, sb_count
    );

endinterface

// File: rtl/store_buffer_sb_fifo.sv
// Generic synchronous FIFO with a combinational head read. Pushes when full
// and pops when empty are ignored.
module sb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]     ram [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = vld[head] ? ram[head] : '0;

    // Payload storage carries no reset; only the bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (do_push)
            ram[tail] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (do_push) begin
                vld[tail] <= 1'b1;
                tail      <= tail + PW'(1);
            end
            if (do_pop) begin
                vld[head] <= 1'b0;
                head      <= head + PW'(1);
            end
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and data memory. Stores
// drain one per cycle; loads pass straight through only once the queue is empty.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave sb
);
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    size;
    } entry_t;

    entry_t                 push_entry;
    entry_t                 head;
    logic                   full;
    logic                   empty;
    logic                   load_ok;
    logic [$clog2(DEPTH):0] count;

    assign push_entry = '{addr: sb.core_addr, data: sb.core_wdata, size: sb.core_size};

    sb_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sb.core_wr_en),
        .pop   (!empty),
        .din   (push_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // A store in the same cycle wins over a load; the load is simply dropped.
    assign load_ok = sb.core_rd_en && !sb.core_wr_en && empty;

    always_comb begin
        sb.mem_wr_en    = 1'b0;
        sb.mem_rd_en    = 1'b0;
        sb.mem_addr     = '0;
        sb.mem_wdata    = '0;
        sb.mem_size     = '0;
        sb.mem_sign_ext = 1'b0;
        sb.core_rdata   = '0;
        sb.core_stall   = 1'b0;
        sb.sb_count     = '0;
        if (!rst) begin
            if (!empty) begin
                sb.mem_wr_en = 1'b1;
                sb.mem_addr  = head.addr;
                sb.mem_wdata = head.data;
                sb.mem_size  = head.size;
            end else if (load_ok) begin
                sb.mem_rd_en    = 1'b1;
                sb.mem_addr     = sb.core_addr;
                sb.mem_size     = sb.core_size;
                sb.mem_sign_ext = sb.core_sign_ext;
                sb.core_rdata   = sb.mem_rdata;
            end
            sb.core_stall = (sb.core_wr_en && full)
                          || (sb.core_rd_en && !sb.core_wr_en && !empty)
                          || (sb.core_fence && !empty);
            sb.sb_count   = count;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } st_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) sbif();
    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .sb(sbif));

    int errors = 0;
    int checks = 0;

    st_t      q[$];
    bit [7:0] dmem [256];
    bit [7:0] emem [256];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ld_fmt(logic [31:0] raw, logic [1:0] sz, logic sx);
        case (sz)
            SIZE_B:  return sx ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            SIZE_H:  return sx ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic int nbytes(logic [1:0] sz);
        return (sz == SIZE_B) ? 1 : (sz == SIZE_H) ? 2 : 4;
    endfunction

    // Data memory: byte-addressed, little-endian, formats reads itself.
    logic [7:0]  ma;
    logic [31:0] mraw;
    always_comb begin
        ma   = sbif.mem_addr[7:0];
        mraw = {dmem[ma + 8'd3], dmem[ma + 8'd2], dmem[ma + 8'd1], dmem[ma]};
        sbif.mem_rdata = sbif.mem_rd_en ? ld_fmt(mraw, sbif.mem_size, sbif.mem_sign_ext) : '0;
    end

    always @(posedge clk) begin
        if (sbif.mem_wr_en)
            for (int k = 0; k < nbytes(sbif.mem_size); k++)
                dmem[sbif.mem_addr[7:0] + 8'(k)] <= sbif.mem_wdata[8*k +: 8];
    end

    // Reference model: an in-order queue, the head retires to emem every cycle.
    always @(posedge clk) begin
        automatic int n0 = q.size();
        if (rst) begin
            q.delete();
        end else begin
            if (n0 != 0) begin
                for (int k = 0; k < nbytes(q[0].size); k++)
                    emem[q[0].addr[7:0] + 8'(k)] <= q[0].data[8*k +: 8];
                void'(q.pop_front());
            end
            if (sbif.core_wr_en && n0 != DEPTH)
                q.push_back('{sbif.core_addr, sbif.core_wdata, sbif.core_size});
        end
    end

    logic [31:0] e_addr, e_wdata, e_rdata, e_raw;
    logic [1:0]  e_size;
    logic        e_wr, e_rd, e_sx, e_stall;
    int          e_cnt;

    always @(negedge clk) begin
        e_wr = 0; e_rd = 0; e_addr = 0; e_wdata = 0; e_size = 0; e_sx = 0;
        e_rdata = 0; e_stall = 0; e_cnt = 0;
        if (!rst) begin
            e_cnt = q.size();
            if (e_cnt != 0) begin
                e_wr = 1; e_addr = q[0].addr; e_wdata = q[0].data; e_size = q[0].size;
            end else if (sbif.core_rd_en && !sbif.core_wr_en) begin
                e_rd = 1; e_addr = sbif.core_addr; e_size = sbif.core_size; e_sx = sbif.core_sign_ext;
                e_raw = {emem[e_addr[7:0] + 8'd3], emem[e_addr[7:0] + 8'd2],
                         emem[e_addr[7:0] + 8'd1], emem[e_addr[7:0]]};
                e_rdata = ld_fmt(e_raw, e_size, e_sx);
            end
            e_stall = (sbif.core_wr_en && e_cnt == DEPTH)
                   || (sbif.core_rd_en && !sbif.core_wr_en && e_cnt != 0)
                   || (sbif.core_fence && e_cnt != 0);
        end
        chk("m_wr_en",    sbif.mem_wr_en,    e_wr);
        chk("m_rd_en",    sbif.mem_rd_en,    e_rd);
        chk("m_addr",     sbif.mem_addr,     e_addr);
        chk("m_wdata",    sbif.mem_wdata,    e_wdata);
        chk("m_size",     sbif.mem_size,     e_size);
        chk("m_sign_ext", sbif.mem_sign_ext, e_sx);
        chk("m_rdata",    sbif.core_rdata,   e_rdata);
        chk("m_stall",    sbif.core_stall,   e_stall);
        chk("m_count",    sbif.sb_count,     e_cnt);
        chk("mem_excl",   sbif.mem_wr_en && sbif.mem_rd_en, 0);
    end

    task automatic set_in(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] sz,
                          input logic sx, input logic fe);
        sbif.core_wr_en = wr; sbif.core_rd_en = rd; sbif.core_addr = a;
        sbif.core_wdata = d;  sbif.core_size = sz;  sbif.core_sign_ext = sx;
        sbif.core_fence = fe;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, SIZE_B, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a load and hold it until serviced; returns stall cycles and data.
    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                           output int stalls, output logic [31:0] data);
        bit done = 0;
        stalls = 0;
        data   = '0;
        set_in(0, 1, a, 0, sz, sx, 0);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (!sbif.core_stall) begin
                data = sbif.core_rdata;
                done = 1;
            end else begin
                stalls++;
            end
            tick();
        end
        if (!done) chk("load_timeout", 1, 0);
        idle();
    endtask

    int          stalls, writes;
    logic [31:0] data;
    bit          done;

    initial begin
        rst = 1;
        set_in(0, 1, 32'h10, 0, SIZE_W, 0, 1);
        @(negedge clk);
        chk("rst_stall", sbif.core_stall, 0);
        chk("rst_rd_en", sbif.mem_rd_en, 0);
        chk("rst_count", sbif.sb_count, 0);
        tick(); tick();
        rst = 0;
        idle();
        @(negedge clk);
        chk("idle_wr_en", sbif.mem_wr_en, 0);
        chk("idle_count", sbif.sb_count, 0);
        tick();

        // single word store then readback
        set_in(1, 0, 32'h10, 32'hDEADBEEF, SIZE_W, 0, 0);
        @(negedge clk);
        chk("sw_stall", sbif.core_stall, 0);
        chk("sw_nowr", sbif.mem_wr_en, 0);
        tick();
        idle();
        @(negedge clk);
        chk("sw_wr_en", sbif.mem_wr_en, 1);
        chk("sw_addr", sbif.mem_addr, 32'h10);
        chk("sw_data", sbif.mem_wdata, 32'hDEADBEEF);
        chk("sw_size", sbif.mem_size, 2);
        chk("sw_count1", sbif.sb_count, 1);
        tick();
        @(negedge clk);
        chk("sw_count0", sbif.sb_count, 0);
        tick();
        do_load(32'h10, SIZE_W, 0, stalls, data);
        chk("lw_data", data, 32'hDEADBEEF);
        chk("lw_stalls", stalls, 0);

        // burst of six stores, no stalls, in order with one cycle lag
        stalls = 0; writes = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 6) set_in(1, 0, 32'h40 + 32'(4 * i), 32'hA5000000 + 32'(i), SIZE_W, 0, 0);
            else idle();
            @(negedge clk);
            if (sbif.core_stall) stalls++;
            if (sbif.mem_wr_en) begin
                writes++;
                if (i >= 1) chk("burst_addr", sbif.mem_addr, 32'h40 + 32'(4 * (i - 1)));
            end
            tick();
        end
        chk("burst_stalls", stalls, 0);
        chk("burst_writes", writes, 6);

        // byte store then sign-extending byte load
        set_in(1, 0, 32'h20, 32'h7F, SIZE_B, 0, 0);
        tick();
        do_load(32'h20, SIZE_B, 1, stalls, data);
        chk("lb7f_stalls", stalls, 1);
        chk("lb7f_data", data, 32'h0000007F);
        set_in(1, 0, 32'h20, 32'h80, SIZE_B, 0, 0);
        tick();
        do_load(32'h20, SIZE_B, 1, stalls, data);
        chk("lb80_stalls", stalls, 1);
        chk("lb80_data", data, 32'hFFFFFF80);

        // fence behind a pending store
        set_in(1, 0, 32'h30, 32'h00001234, SIZE_W, 0, 0);
        tick();
        set_in(0, 0, 0, 0, SIZE_B, 0, 1);
        stalls = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (sbif.core_stall) stalls++;
            else begin
                chk("fence_count", sbif.sb_count, 0);
                done = 1;
            end
            tick();
        end
        if (!done) chk("fence_timeout", 1, 0);
        chk("fence_stalls", stalls, 1);
        idle();

        // reset while a store is still queued: it must never reach memory
        set_in(1, 0, 32'h80, 32'hCAFEF00D, SIZE_W, 0, 0);
        tick();
        idle();
        rst = 1;
        @(negedge clk);
        chk("rstd_wr_during", sbif.mem_wr_en, 0);
        tick();
        rst = 0;
        @(negedge clk);
        chk("rstd_count", sbif.sb_count, 0);
        chk("rstd_wr_after", sbif.mem_wr_en, 0);
        tick();
        do_load(32'h80, SIZE_W, 0, stalls, data);
        chk("rstd_mem", data, 32'h0);

        // illegal store+load: store wins, load ignored
        set_in(1, 1, 32'h50, 32'h55, SIZE_W, 0, 0);
        @(negedge clk);
        chk("ill_rd_en", sbif.mem_rd_en, 0);
        chk("ill_stall", sbif.core_stall, 0);
        tick();
        idle();
        @(negedge clk);
        chk("ill_wr_en", sbif.mem_wr_en, 1);
        chk("ill_addr", sbif.mem_addr, 32'h50);
        tick();
        do_load(32'h50, SIZE_W, 0, stalls, data);
        chk("ill_data", data, 32'h55);

        // random traffic, including occasional illegal pairs and resets
        for (int i = 0; i < 300; i++) begin
            automatic int          r  = $urandom_range(0, 99);
            automatic logic [1:0]  sz = 2'($urandom_range(0, 2));
            automatic logic [31:0] a  = 32'($urandom_range(0, 63) * 4)
                                      + ((sz == SIZE_B) ? 32'($urandom_range(0, 3))
                                       : (sz == SIZE_H) ? 32'($urandom_range(0, 1) * 2) : 32'h0);
            set_in(r < 40 || r >= 97, (r >= 40 && r < 75) || r >= 97, a, $urandom, sz,
                   1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst = 0;
        idle();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
